// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu_issue sequencer: opcodes, FSM states,
// program-word field positions and data widths.
package cpu_pkg;

  localparam int WORD_W  = 9;
  localparam int DATA_W  = 8;
  localparam int INSTR_W = 19;
  localparam int NREGS   = 4;
  localparam int RADDR_W = 2;

  localparam logic [2:0] OP_HALT = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_INC  = 3'b011;
  localparam logic [2:0] OP_DEC  = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_OR   = 3'b110;
  localparam logic [2:0] OP_NOT  = 3'b111;

  // Program word: [8:6] opcode, [5:4] rd, [3:2] rs1, [1:0] rs2
  localparam int OP_MSB  = 8;
  localparam int OP_LSB  = 6;
  localparam int RD_MSB  = 5;
  localparam int RD_LSB  = 4;
  localparam int RS1_MSB = 3;
  localparam int RS1_LSB = 2;
  localparam int RS2_MSB = 1;
  localparam int RS2_LSB = 0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    ISSUE = 3'd2,
    WB    = 3'd3,
    DONE  = 3'd4
  } state_t;

  typedef struct packed {
    logic [2:0]         op;
    logic [RADDR_W-1:0] rd;
    logic [RADDR_W-1:0] rs1;
    logic [RADDR_W-1:0] rs2;
  } pword_t;

  function automatic pword_t decode(input logic [WORD_W-1:0] w);
    pword_t p;
    p.op  = w[OP_MSB:OP_LSB];
    p.rd  = w[RD_MSB:RD_LSB];
    p.rs1 = w[RS1_MSB:RS1_LSB];
    p.rs2 = w[RS2_MSB:RS2_LSB];
    return p;
  endfunction

endpackage

// File: rtl/cpu_regfile.sv
// 4x8 register file: one write port, two operand read ports and a host
// read port, all reads combinational.
module cpu_regfile
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [RADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic [RADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0]  rd_data_a,
  input  logic [RADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0]  rd_data_b,
  input  logic [RADDR_W-1:0] host_rd_addr,
  output logic [DATA_W-1:0]  host_rd_data
);

  logic [DATA_W-1:0] regs [NREGS];

  // NOTE: this small flop array is reset because a program may read a register
  // that was never written; a RAM macro could not be cleared this way. The
  // non-blocking assignments keep every flop updating from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a    = regs[rd_addr_a];
  assign rd_data_b    = regs[rd_addr_b];
  assign host_rd_data = regs[host_rd_addr];

endmodule

// File: rtl/cpu_issue.sv
// Fetch/issue/writeback sequencer driving the combinational ALU instruction bus.
// Optional retired-instruction counter: define CPU_ISSUE_RETIRE_CNT_EN.
module cpu_issue
  import cpu_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               done,
  output logic               busy,
  output logic               imem_en,
  output logic [AW-1:0]      imem_addr,
  input  logic [WORD_W-1:0]  imem_data,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid,
  input  logic [DATA_W-1:0]  alu_result,
  input  logic               reg_wr_en,
  input  logic [RADDR_W-1:0] reg_wr_addr,
  input  logic [DATA_W-1:0]  reg_wr_data,
  input  logic [RADDR_W-1:0] reg_rd_addr,
  output logic [DATA_W-1:0]  reg_rd_data
`ifdef CPU_ISSUE_RETIRE_CNT_EN
  ,
  output logic [15:0]        retired
`endif
);

  state_t               state_q, state_d;
  logic [AW-1:0]        pc_q;
  logic [INSTR_W-1:0]   ir_q;
  logic [RADDR_W-1:0]   rd_q;
  pword_t               word;
  logic [DATA_W-1:0]    op_a, op_b;
  logic                 rf_wr_en;
  logic [RADDR_W-1:0]   rf_wr_addr;
  logic [DATA_W-1:0]    rf_wr_data;
  logic                 issue_go;

  assign word     = decode(imem_data);
  assign issue_go = (state_q == ISSUE) && (word.op != OP_HALT);

  // WB owns the write port; the host only gets it while the sequencer is idle.
  assign rf_wr_en   = (state_q == WB) || ((state_q == IDLE) && reg_wr_en);
  assign rf_wr_addr = (state_q == WB) ? rd_q       : reg_wr_addr;
  assign rf_wr_data = (state_q == WB) ? alu_result : reg_wr_data;

  cpu_regfile u_regfile (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (rf_wr_en),
    .wr_addr      (rf_wr_addr),
    .wr_data      (rf_wr_data),
    .rd_addr_a    (word.rs1),
    .rd_data_a    (op_a),
    .rd_addr_b    (word.rs2),
    .rd_data_b    (op_b),
    .host_rd_addr (reg_rd_addr),
    .host_rd_data (reg_rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    done        = 1'b0;
    busy        = 1'b1;
    imem_en     = 1'b0;
    instr_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) state_d = FETCH;
      end
      FETCH: begin
        imem_en = 1'b1;
        state_d = ISSUE;
      end
      ISSUE: begin
        state_d = (word.op == OP_HALT) ? DONE : WB;
      end
      WB: begin
        instr_valid = 1'b1;
        state_d     = (pc_q == {AW{1'b1}}) ? DONE : FETCH;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= '0;
    end else if (state_q == WB) begin
      pc_q <= pc_q + AW'(1);
    end else if (state_q == DONE) begin
      pc_q <= '0;
    end
  end

  // Operands are captured from the pre-writeback register values, so rd==rs is safe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_q <= '0;
      rd_q <= '0;
    end else if (issue_go) begin
      ir_q <= {word.op, op_a, op_b};
      rd_q <= word.rd;
    end
  end

  assign imem_addr = pc_q;
  assign instr_out = ir_q;

`ifdef CPU_ISSUE_RETIRE_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired <= '0;
    end else if ((state_q == IDLE) && start) begin
      retired <= '0;
    end else if ((state_q == WB) && (retired != 16'hFFFF)) begin
      retired <= retired + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_issue.sv
// Self-checking bench for cpu_issue: table of programs with expected results,
// an ALU and synchronous instruction-memory model, and an instr_out scoreboard.
module tb_cpu_issue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        done, busy, imem_en, instr_valid;
  logic [3:0]  imem_addr;
  logic [8:0]  imem_data = '0;
  logic [18:0] instr_out;
  logic [7:0]  alu_result;
  logic        reg_wr_en = 1'b0;
  logic [1:0]  reg_wr_addr = '0;
  logic [7:0]  reg_wr_data = '0;
  logic [1:0]  reg_rd_addr = '0;
  logic [7:0]  reg_rd_data;
`ifdef CPU_ISSUE_RETIRE_CNT_EN
  logic [15:0] retired;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [8:0]  prog_mem [16];
  logic [18:0] sb_q [$];

  typedef struct {
    logic [3:0][7:0]  init;
    logic [15:0][8:0] prog;
    int               exp_done;
    int               exp_first;
    logic [3:0][7:0]  exp_regs;
    int               exp_retired;
  } vec_t;

  vec_t vecs [5];

  cpu_issue #(.AW(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .done        (done),
    .busy        (busy),
    .imem_en     (imem_en),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .alu_result  (alu_result),
    .reg_wr_en   (reg_wr_en),
    .reg_wr_addr (reg_wr_addr),
    .reg_wr_data (reg_wr_data),
    .reg_rd_addr (reg_rd_addr),
    .reg_rd_data (reg_rd_data)
`ifdef CPU_ISSUE_RETIRE_CNT_EN
    ,
    .retired     (retired)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'b001:  return a + b;
      3'b010:  return a - b;
      3'b011:  return a + 8'd1;
      3'b100:  return a - 8'd1;
      3'b101:  return a & b;
      3'b110:  return a | b;
      3'b111:  return ~a;
      default: return 8'h00;
    endcase
  endfunction

  assign alu_result = alu(instr_out[18:16], instr_out[15:8], instr_out[7:0]);

  always @(posedge clk) if (imem_en) imem_data <= prog_mem[imem_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic host_write(input logic [1:0] a, input logic [7:0] d);
    reg_wr_en   = 1'b1;
    reg_wr_addr = a;
    reg_wr_data = d;
    @(posedge clk);
    #1 reg_wr_en = 1'b0;
  endtask

  task automatic check_regs(input string tag, input logic [3:0][7:0] exp);
    for (int r = 0; r < 4; r++) begin
      reg_rd_addr = 2'(r);
      #1 check($sformatf("%s r%0d", tag, r), 32'(reg_rd_data), 32'(exp[r]));
    end
  endtask

  // Loads registers and program, fills the scoreboard from a reference model.
  task automatic prepare(input vec_t v);
    logic [7:0] m [4];
    logic [8:0] w;
    for (int r = 0; r < 4; r++) host_write(2'(r), v.init[r]);
    for (int a = 0; a < 16; a++) prog_mem[a] = v.prog[a];
    sb_q.delete();
    for (int r = 0; r < 4; r++) m[r] = v.init[r];
    for (int a = 0; a < 16; a++) begin
      w = v.prog[a];
      if (w[8:6] == 3'b000) break;
      sb_q.push_back({w[8:6], m[w[3:2]], m[w[1:0]]});
      m[w[5:4]] = alu(w[8:6], m[w[3:2]], m[w[1:0]]);
    end
  endtask

  task automatic run_vec(input vec_t v, input bit inject, input string tag);
    int done_cnt = 0;
    int done_cyc = 0;
    int first    = 0;
    logic [18:0] exp_i;
    prepare(v);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int cyc = 1; cyc <= v.exp_done + 3; cyc++) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (instr_valid) begin
        if (first == 0) first = cyc;
        if (sb_q.size() == 0) begin
          check($sformatf("%s unexpected instr_valid cyc%0d", tag, cyc), 32'(instr_valid), 32'd0);
        end else begin
          exp_i = sb_q.pop_front();
          check($sformatf("%s instr_out cyc%0d", tag, cyc), 32'(instr_out), 32'(exp_i));
        end
      end
      if (inject && cyc == 2) begin
        start       = 1'b1;
        reg_wr_en   = 1'b1;
        reg_wr_addr = 2'd1;
        reg_wr_data = 8'hAA;
      end
      if (inject && cyc == 5) begin
        start     = 1'b0;
        reg_wr_en = 1'b0;
      end
    end
    check({tag, " done pulses"}, 32'(done_cnt), 32'd1);
    check({tag, " done cycle"}, 32'(done_cyc), 32'(v.exp_done));
    check({tag, " first instr_valid cycle"}, 32'(first), 32'(v.exp_first));
    check({tag, " scoreboard leftover"}, 32'(sb_q.size()), 32'd0);
    check({tag, " busy after run"}, 32'(busy), 32'd0);
    check({tag, " pc back to 0"}, 32'(imem_addr), 32'd0);
`ifdef CPU_ISSUE_RETIRE_CNT_EN
    check({tag, " retired"}, 32'(retired), 32'(v.exp_retired));
`endif
    check_regs(tag, v.exp_regs);
  endtask

  task automatic fill_vecs();
    vec_t v;
    // ADD r2,r0,r1 ; HALT
    v = '{default: '0};
    v.init[0] = 8'h05; v.init[1] = 8'h03;
    v.prog[0] = 9'h061;
    v.exp_done = 6; v.exp_first = 3; v.exp_retired = 1;
    v.exp_regs[0] = 8'h05; v.exp_regs[1] = 8'h03; v.exp_regs[2] = 8'h08; v.exp_regs[3] = 8'h00;
    vecs[0] = v;
    // SUB r2,r0,r1 ; NOT r3,r2,r0 ; HALT
    v = '{default: '0};
    v.init[0] = 8'h03; v.init[1] = 8'h05;
    v.prog[0] = 9'h0A1; v.prog[1] = 9'h1F8;
    v.exp_done = 9; v.exp_first = 3; v.exp_retired = 2;
    v.exp_regs[0] = 8'h03; v.exp_regs[1] = 8'h05; v.exp_regs[2] = 8'hFE; v.exp_regs[3] = 8'h01;
    vecs[1] = v;
    // 16 x INC r0,r0,r0, ends by pc wrap
    v = '{default: '0};
    v.init[0] = 8'hFF;
    for (int a = 0; a < 16; a++) v.prog[a] = 9'h0C0;
    v.exp_done = 49; v.exp_first = 3; v.exp_retired = 16;
    v.exp_regs[0] = 8'h0F;
    vecs[2] = v;
    // HALT at word 0
    v = '{default: '0};
    v.init[0] = 8'h11; v.init[1] = 8'h22; v.init[2] = 8'h33; v.init[3] = 8'h44;
    v.exp_done = 3; v.exp_first = 0; v.exp_retired = 0;
    v.exp_regs = v.init;
    vecs[3] = v;
    // AND r2,r0,r1 ; OR r3,r0,r1 ; DEC r0,r0,r1 ; INC r1,r1,r1 ; HALT
    v = '{default: '0};
    v.init[0] = 8'hF0; v.init[1] = 8'h3C;
    v.prog[0] = 9'h161; v.prog[1] = 9'h1B1; v.prog[2] = 9'h101; v.prog[3] = 9'h0D5;
    v.exp_done = 15; v.exp_first = 3; v.exp_retired = 4;
    v.exp_regs[0] = 8'hEF; v.exp_regs[1] = 8'h3D; v.exp_regs[2] = 8'h30; v.exp_regs[3] = 8'hFC;
    vecs[4] = v;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_cnt;
    logic [3:0][7:0] zeros;
    zeros = '0;
    fill_vecs();
    for (int a = 0; a < 16; a++) prog_mem[a] = '0;

    #12;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset imem_en", 32'(imem_en), 32'd0);
    check("reset instr_valid", 32'(instr_valid), 32'd0);
    check("reset instr_out", 32'(instr_out), 32'd0);
    check_regs("reset", zeros);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 5; i++) run_vec(vecs[i], 1'b0, $sformatf("vec%0d", i));

    // Host write and second start during a run must both be ignored.
    run_vec(vecs[0], 1'b1, "ignore");

    // Reset during WB of the first ADD aborts the run.
    prepare(vecs[0]);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    done_cnt = 0;
    for (int cyc = 1; cyc <= 3; cyc++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("abort in WB", 32'(instr_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort instr_valid", 32'(instr_valid), 32'd0);
    check("abort imem_en", 32'(imem_en), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort instr_out", 32'(instr_out), 32'd0);
    check("abort pc", 32'(imem_addr), 32'd0);
    check_regs("abort", zeros);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("abort done pulses", 32'(done_cnt), 32'd0);
    run_vec(vecs[0], 1'b0, "post_abort");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu_issue.md
# cpu_issue

Sequencer that drives the 19-bit instruction bus of the combinational ALU/CU (`cu`) and consumes its 8-bit result. It owns a 4x8 register file and a program counter, fetches 9-bit program words from an external synchronous instruction memory, and forms each `{opcode, operand1, operand2}` word. It writes the ALU result back to the register file. Software preloads registers through a host port, pulses `start`, and waits for `done`.

## Interface
- `AW`, 4: program-counter width; program depth is 2^AW words.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  run request; sampled only in IDLE.
- `done`  out  1  one-cycle pulse when a run ends.
- `busy`  out  1  high in every state except IDLE.
- `imem_en`  out  1  instruction-memory read enable.
- `imem_addr`  out  AW  read address; equals `pc`.
- `imem_data`  in  9  program word, valid one cycle after `imem_en`.
- `instr_out`  out  19  to ALU: [18:16] opcode, [15:8] operand1, [7:0] operand2.
- `instr_valid`  out  1  `instr_out` is stable and is being executed.
- `alu_result`  in  8  ALU result; combinational from `instr_out`.
- `reg_wr_en`  in  1  host register write; honoured only in IDLE.
- `reg_wr_addr`  in  2  host write address.
- `reg_wr_data`  in  8  host write data.
- `reg_rd_addr`  in  2  host read address.
- `reg_rd_data`  out  8  combinational read of `regs[reg_rd_addr]`.

## Operation
- **Program word format:**
  - [8:6] opcode: 001 add, 010 sub, 011 inc, 100 dec, 101 and, 110 or, 111 not.
  - [5:4] rd, [3:2] rs1, [1:0] rs2.
  - Opcode 000 is HALT.
- **IDLE:**
  - `start` moves to FETCH.
  - `reg_wr_en` writes the register file.
- **FETCH:**
  - `imem_en`=1 and `imem_addr`=`pc`.
  - Always moves to ISSUE.
- **ISSUE:**
  - `imem_data` is decoded.
  - If the opcode is HALT, move to DONE; `pc` and the registers are unchanged.
  - Otherwise, at the clock edge, register `instr_out` = {op, regs[rs1], regs[rs2]}, latch rd, and move to WB.
- **WB:**
  - `instr_valid`=1.
  - At the clock edge, `regs[rd]` <= `alu_result` and `pc` <= `pc`+1 (modulo 2^AW).
  - If `pc` was 2^AW−1, move to DONE; otherwise move to FETCH.
- **DONE:**
  - `done`=1 for one cycle.
  - `pc` returns to 0.
  - Move to IDLE.
- Operand read uses the register values current in ISSUE, so rd==rs1/rs2 reads the old value. Every WB completes before the next ISSUE, so there are no hazards.
- `start` outside IDLE is ignored.
- `reg_wr_en` outside IDLE is ignored; the register file is never dual-written.
- Unary ops (inc, dec, not) still place regs[rs2] in operand2; the ALU ignores it.
- Reset values:
  - state IDLE; `pc`, all regs, `instr_out`, rd latch = 0.
  - `done`, `busy`, `imem_en`, `instr_valid` = 0.
- Reset mid-run aborts immediately. No writeback completes and `done` is not pulsed.

## Timing
- `start` is sampled high at edge 0, so FETCH occupies cycle 1.
- Each executed instruction costs 3 cycles: FETCH, ISSUE, WB.
- A HALT costs 2 cycles: FETCH, ISSUE.
- N instructions followed by HALT: `done` is high in cycle 3N+3.
- A run ended by pc wrap (N = 2^AW, no HALT): `done` is high in cycle 3N+1.
- `instr_out` changes only at the ISSUE→WB edge and holds its value at all other times.
- `alu_result` is sampled at the end of WB, one full cycle after `instr_out` updates.
- `busy` is 0 in the DONE→IDLE cycle following the `done` pulse. `start` may be reasserted in that IDLE cycle.

## Configuration
- `CPU_ISSUE_RETIRE_CNT_EN` defined:
  - Adds output `retired` [15:0], reset to 0.
  - Increments at each WB edge and saturates at 16'hFFFF.
  - Cleared when `start` is accepted.
  - HALT does not count.
- Macro undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- The shared package `cpu_pkg` holds:
  - opcode localparams (OP_HALT=3'b000 through OP_NOT=3'b111);
  - state encoding (IDLE, FETCH, ISSUE, WB, DONE);
  - program-word field positions.
- One sub-module, `cpu_regfile`:
  - 4x8 register file, async reset;
  - two combinational read ports (operands) plus the host read port;
  - one write port, muxed between host (IDLE) and WB.
- FSM, pc, and instruction register live in `cpu_issue`.

## Test plan
- Host writes r0=5, r1=3; program {ADD r2,r0,r1; HALT}; start. Expect:
  - `instr_out`=19'h10503 with `instr_valid` in cycle 3;
  - `done` in cycle 6;
  - `reg_rd_data`(r2)=8.
- r0=3, r1=5; program {SUB r2,r0,r1; NOT r3,r2,r0; HALT}. Expect:
  - r2=8'hFE, r3=8'h01;
  - `done` in cycle 9.
- r0=8'hFF; 16 x INC r0,r0,r0 with no HALT (AW=4). Expect:
  - r0=8'h0F;
  - `done` in cycle 49;
  - `retired`=16 when the macro is defined;
  - `pc` back to 0.
- During a run, assert `reg_wr_en` (r1=8'hAA) and a second `start`. Expect both ignored: r1 unchanged, exactly one `done` pulse.
- Assert `rst` during WB of the first ADD. Expect:
  - all outputs and regs at reset values immediately;
  - no `done` pulse;
  - a subsequent normal run is correct.
- Program word 0 = HALT. Expect:
  - `done` in cycle 3;
  - `instr_valid` never asserted;
  - registers unchanged.
